systolic_mm_seq: RTL and testbench

- Sequencing controller for the 3x3 systolic matrix-multiply array (PE/De grid).
- Accepts a full A/B operand job through a valid/ready handshake and registers it.
- Drives the skewed 5-lane wavefront into the array edges, gates the array, and captures the nine accumulators from the array's output taps at fixed cycles.
- Returns the C matrix through a valid/ready handshake. It replaces ad hoc free-running case-counter sequencing with a restartable, abortable FSM.

---
 rtl/systolic_mm_pkg.sv | 15 +
 rtl/skew_feed_mux.sv | 28 ++
 rtl/systolic_mm_seq.sv | 122 ++++++++++++
 tb/tb_systolic_mm_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_mm_pkg.sv
// systolic_mm_pkg: shared types, lane map and defaults for the systolic matmul sequencer
package systolic_mm_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_FEED, S_DRAIN, S_CAPT, S_DONE} state_t;
  localparam int DW_DEF = 8;
  localparam int RW_DEF = 18;
  localparam int CAP0_DEF = 6;
  localparam int LANE_PE19 = 0;
  localparam int LANE_PE16 = 1;
  localparam int LANE_PE12 = 2;
  localparam int LANE_PE18 = 3;
  localparam int LANE_PE17 = 4;
  function automatic int elem_lsb(input int n, input int w);
    return (n - 1) * w;
  endfunction
endpackage

// File: rtl/skew_feed_mux.sv
// skew_feed_mux: maps wave index and latched operands onto the skewed 5-lane array edges
module skew_feed_mux
  import systolic_mm_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic            i_en,
  input  logic [1:0]      i_wave,
  input  logic [9*DW-1:0] i_a,
  input  logic [9*DW-1:0] i_b,
  output logic [5*DW-1:0] o_feed_a,
  output logic [5*DW-1:0] o_feed_b
);
  logic [3*DW-1:0] w_row [3];
  logic [3*DW-1:0] w_col [3];
  logic [3*DW-1:0] w_ra;
  logic [3*DW-1:0] w_cb;
  for (genvar r = 0; r < 3; r++) begin : g_rc
    assign w_row[r] = i_a[elem_lsb(3*r+1, DW) +: 3*DW];
    assign w_col[r] = {i_b[elem_lsb(r+7, DW) +: DW], i_b[elem_lsb(r+4, DW) +: DW],
                       i_b[elem_lsb(r+1, DW) +: DW]};
  end
  assign w_ra = i_wave == 2'd0 ? w_row[0] : i_wave == 2'd1 ? w_row[1] : w_row[2];
  assign w_cb = i_wave == 2'd0 ? w_col[0] : i_wave == 2'd1 ? w_col[1] : w_col[2];
  // wave w occupies lanes w..w+2
  assign o_feed_a = i_en ? ({{(2*DW){1'b0}}, w_ra} << (i_wave * DW)) : '0;
  assign o_feed_b = i_en ? ({{(2*DW){1'b0}}, w_cb} << (i_wave * DW)) : '0;
endmodule

// File: rtl/systolic_mm_seq.sv
// systolic_mm_seq: restartable, abortable job sequencer for the 3x3 systolic matmul array
module systolic_mm_seq
  import systolic_mm_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int RW   = RW_DEF,
  parameter int CAP0 = CAP0_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [9*DW-1:0] a_mat,
  input  logic [9*DW-1:0] b_mat,
  input  logic            abort,
  output logic [5*DW-1:0] feed_a,
  output logic [5*DW-1:0] feed_b,
  output logic            pe_clr,
  output logic            pe_en,
  input  logic [5*RW-1:0] acc_tap,
  output logic [9*RW-1:0] c_mat,
  output logic            res_valid,
  input  logic            res_ready
);
  if (CAP0 < 3 || CAP0 + 2 > 15) begin : g_bad_cap0
    $error("CAP0 must satisfy 3 <= CAP0 <= 13");
  end
  localparam logic [3:0] K_LAST = 4'(CAP0 - 1);
  localparam logic [3:0] K_CAP  = 4'(CAP0);
  localparam logic [3:0] K_CAP1 = 4'(CAP0 + 1);
  localparam logic [3:0] K_END  = 4'(CAP0 + 2);
  state_t          r_state, w_nxt;
  logic [3:0]      r_k, w_k_nxt;
  logic [9*DW-1:0] r_a, r_b;
  logic [5*DW-1:0] r_feed_a, r_feed_b, w_feed_a, w_feed_b;
  logic            r_pe_clr, r_pe_en, r_res_valid, r_start_ready;
  logic            w_abort, w_run;
  logic [RW-1:0]   r_c [9];
  logic [RW-1:0]   w_tap [5];
  assign w_abort = abort && r_state != S_IDLE;
  assign w_run   = r_state inside {S_FEED, S_DRAIN, S_CAPT};
  assign w_k_nxt = w_run ? r_k + 4'd1 : 4'd0;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  w_nxt = start_valid ? S_CLR : S_IDLE;
      S_CLR:   w_nxt = S_FEED;
      S_FEED:  w_nxt = r_k == K_LAST ? S_CAPT : r_k == 4'd2 ? S_DRAIN : S_FEED;
      S_DRAIN: w_nxt = r_k == K_LAST ? S_CAPT : S_DRAIN;
      S_CAPT:  w_nxt = r_k == K_END ? S_DONE : S_CAPT;
      S_DONE:  w_nxt = res_ready ? S_IDLE : S_DONE;
      default: w_nxt = S_IDLE;
    endcase
    if (w_abort) w_nxt = S_IDLE;
  end
  // outputs are registered from next-state so they line up with the cycle they describe
  skew_feed_mux #(.DW(DW)) u_mux (
    .i_en    (w_nxt == S_FEED),
    .i_wave  (w_k_nxt[1:0]),
    .i_a     (r_a),
    .i_b     (r_b),
    .o_feed_a(w_feed_a),
    .o_feed_b(w_feed_b)
  );
  for (genvar l = 0; l < 5; l++) begin : g_tap
    assign w_tap[l] = acc_tap[l*RW +: RW];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_k           <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_feed_a      <= '0;
      r_feed_b      <= '0;
      r_pe_clr      <= 1'b0;
      r_pe_en       <= 1'b0;
      r_res_valid   <= 1'b0;
      r_start_ready <= 1'b1;
      r_c           <= '{default: '0};
    end else begin
      r_state       <= w_nxt;
      r_k           <= w_k_nxt;
      r_feed_a      <= w_feed_a;
      r_feed_b      <= w_feed_b;
      r_pe_clr      <= w_nxt == S_CLR;
      r_pe_en       <= w_nxt inside {S_FEED, S_DRAIN, S_CAPT};
      r_res_valid   <= w_nxt == S_DONE;
      r_start_ready <= w_nxt == S_IDLE;
      if (r_state == S_IDLE && start_valid) begin
        r_a <= a_mat;
        r_b <= b_mat;
      end
      if (w_abort) begin
        r_c <= '{default: '0};
      end else if (r_state == S_CAPT) begin
        if (r_k == K_CAP) begin
          r_c[0] <= w_tap[LANE_PE19];
          r_c[1] <= w_tap[LANE_PE16];
          r_c[2] <= w_tap[LANE_PE12];
          r_c[3] <= w_tap[LANE_PE18];
          r_c[6] <= w_tap[LANE_PE17];
        end
        if (r_k == K_CAP1) begin
          r_c[4] <= w_tap[LANE_PE19];
          r_c[5] <= w_tap[LANE_PE16];
          r_c[7] <= w_tap[LANE_PE18];
        end
        if (r_k == K_END) r_c[8] <= w_tap[LANE_PE19];
      end
    end
  end
  for (genvar n = 0; n < 9; n++) begin : g_c
    assign c_mat[n*RW +: RW] = r_c[n];
  end
  assign feed_a      = r_feed_a;
  assign feed_b      = r_feed_b;
  assign pe_clr      = r_pe_clr;
  assign pe_en       = r_pe_en;
  assign res_valid   = r_res_valid;
  assign start_ready = r_start_ready;
endmodule

// File: tb/tb_systolic_mm_seq.sv
// tb_systolic_mm_seq: directed bench with a behavioural 3x3 array model driving acc_tap
module tb_systolic_mm_seq;
  localparam int DW = 8;
  localparam int RW = 18;
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start_valid = 1'b0;
  logic            start_ready;
  logic [9*DW-1:0] a_mat = '0;
  logic [9*DW-1:0] b_mat = '0;
  logic            abort = 1'b0;
  logic [5*DW-1:0] feed_a, feed_b;
  logic            pe_clr, pe_en;
  logic [5*RW-1:0] acc_tap;
  logic [9*RW-1:0] c_mat;
  logic            res_valid;
  logic            res_ready = 1'b0;
  int              n_vec = 0;
  int              n_err = 0;
  int              cyc;
  int              kk = 0;
  logic [DW-1:0]   ra [3][5];
  logic [DW-1:0]   cb [3][5];
  int              cm [3][3];
  logic [9*DW-1:0] a1, b1, ai, bi, amax;
  logic [9*RW-1:0] c1;

  systolic_mm_seq #(.DW(DW), .RW(RW), .CAP0(6)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .a_mat(a_mat), .b_mat(b_mat), .abort(abort), .feed_a(feed_a), .feed_b(feed_b),
    .pe_clr(pe_clr), .pe_en(pe_en), .acc_tap(acc_tap), .c_mat(c_mat),
    .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  // array model: records the three waves, forms C, and exposes it on the taps only at the capture cycles
  always @(posedge clk) begin
    if (pe_clr) kk <= 0;
    else if (pe_en) begin
      kk <= kk + 1;
      if (kk < 3)
        for (int l = 0; l < 5; l++) begin
          ra[kk][l] <= feed_a[l*DW +: DW];
          cb[kk][l] <= feed_b[l*DW +: DW];
        end
    end
  end
  always_comb begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        cm[i][j] = 0;
        for (int k = 0; k < 3; k++) cm[i][j] += int'(ra[i][i+k]) * int'(cb[j][j+k]);
      end
  end
  always_comb begin
    for (int l = 0; l < 5; l++) acc_tap[l*RW +: RW] = RW'(32'h15555 + kk * 5 + l);
    if (kk == 6) begin
      acc_tap[0*RW +: RW] = RW'(cm[0][0]);
      acc_tap[1*RW +: RW] = RW'(cm[0][1]);
      acc_tap[2*RW +: RW] = RW'(cm[0][2]);
      acc_tap[3*RW +: RW] = RW'(cm[1][0]);
      acc_tap[4*RW +: RW] = RW'(cm[2][0]);
    end
    if (kk == 7) begin
      acc_tap[0*RW +: RW] = RW'(cm[1][1]);
      acc_tap[1*RW +: RW] = RW'(cm[1][2]);
      acc_tap[3*RW +: RW] = RW'(cm[2][1]);
    end
    if (kk == 8) acc_tap[0*RW +: RW] = RW'(cm[2][2]);
  end

  function automatic logic [5*DW-1:0] pk5(input int x0, x1, x2, x3, x4);
    return {DW'(x4), DW'(x3), DW'(x2), DW'(x1), DW'(x0)};
  endfunction
  function automatic logic [9*DW-1:0] pk9(input int x1, x2, x3, x4, x5, x6, x7, x8, x9);
    return {DW'(x9), DW'(x8), DW'(x7), DW'(x6), DW'(x5), DW'(x4), DW'(x3), DW'(x2), DW'(x1)};
  endfunction
  function automatic logic [9*RW-1:0] pkc(input int x1, x2, x3, x4, x5, x6, x7, x8, x9);
    return {RW'(x9), RW'(x8), RW'(x7), RW'(x6), RW'(x5), RW'(x4), RW'(x3), RW'(x2), RW'(x1)};
  endfunction

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [9*DW-1:0] a, input logic [9*DW-1:0] b);
    chk("start_ready", start_ready, 1);
    a_mat = a;
    b_mat = b;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
  endtask

  task automatic wait_res(inout int c);
    while (!res_valid && c < 30) begin
      step();
      c++;
    end
  endtask

  initial begin
    a1   = pk9(1, 2, 3, 4, 5, 6, 7, 8, 9);
    b1   = pk9(9, 8, 7, 6, 5, 4, 3, 2, 1);
    c1   = pkc(30, 24, 18, 84, 69, 54, 138, 114, 90);
    ai   = pk9(1, 0, 0, 0, 1, 0, 0, 0, 1);
    bi   = pk9(1, 2, 3, 4, 5, 6, 7, 8, 9);
    amax = pk9(255, 255, 255, 255, 255, 255, 255, 255, 255);
    repeat (3) step();
    chk("rst_sr", start_ready, 1);
    chk("rst_en", pe_en, 0);
    chk("rst_clr", pe_clr, 0);
    chk("rst_rv", res_valid, 0);
    chk("rst_fa", feed_a, 0);
    chk("rst_c", c_mat, 0);
    rst_n = 1'b1;
    step();
    start_job(a1, b1);
    cyc = 1;
    chk("clr", pe_clr, 1);
    chk("clr_en", pe_en, 0);
    chk("clr_sr", start_ready, 0);
    step(); cyc = 2;
    chk("w0_a", feed_a, pk5(1, 2, 3, 0, 0));
    chk("w0_b", feed_b, pk5(9, 6, 3, 0, 0));
    chk("w0_en", pe_en, 1);
    step(); cyc = 3;
    chk("w1_a", feed_a, pk5(0, 4, 5, 6, 0));
    chk("w1_b", feed_b, pk5(0, 8, 5, 2, 0));
    step(); cyc = 4;
    chk("w2_a", feed_a, pk5(0, 0, 7, 8, 9));
    chk("w2_b", feed_b, pk5(0, 0, 7, 4, 1));
    step(); cyc = 5;
    chk("drain_fa", feed_a, 0);
    wait_res(cyc);
    chk("lat_nom", cyc, 11);
    chk("c_nom", c_mat, c1);
    chk("done_en", pe_en, 0);
    a_mat = amax;
    repeat (5) begin
      start_valid = 1'b1;
      step();
      chk("bp_c", c_mat, c1);
      chk("bp_sr", start_ready, 0);
      chk("bp_rv", res_valid, 1);
      chk("bp_clr", pe_clr, 0);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("rel_rv", res_valid, 0);
    chk("rel_sr", start_ready, 1);
    chk("rel_c", c_mat, c1);
    start_job(a1, b1);
    repeat (5) step();
    chk("ab_pre", pe_en, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_en", pe_en, 0);
    chk("ab_c", c_mat, 0);
    chk("ab_sr", start_ready, 1);
    chk("ab_rv", res_valid, 0);
    start_job(ai, bi);
    cyc = 1;
    wait_res(cyc);
    chk("lat_id", cyc, 11);
    chk("c_id", c_mat, pkc(1, 2, 3, 4, 5, 6, 7, 8, 9));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    start_job(a1, b1);
    cyc = 1;
    wait_res(cyc);
    chk("c_b2b1", c_mat, c1);
    a_mat = amax;
    b_mat = amax;
    start_valid = 1'b1;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("b2b_sr", start_ready, 1);
    chk("b2b_rv", res_valid, 0);
    step();
    start_valid = 1'b0;
    cyc = 1;
    chk("b2b_clr", pe_clr, 1);
    chk("b2b_hold", c_mat, c1);
    wait_res(cyc);
    chk("lat_max", cyc, 11);
    chk("c_max", c_mat, pkc(195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    start_job(a1, b1);
    step();
    step();
    chk("rs_pre", pe_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_sr", start_ready, 1);
    chk("rs_en", pe_en, 0);
    chk("rs_clr", pe_clr, 0);
    chk("rs_fa", feed_a, 0);
    chk("rs_fb", feed_b, 0);
    chk("rs_c", c_mat, 0);
    chk("rs_rv", res_valid, 0);
    step();
    rst_n = 1'b1;
    repeat (4) begin
      step();
      chk("rs_idle_en", pe_en, 0);
      chk("rs_idle_sr", start_ready, 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
